// File: rtl/c10_bist_ctrl.sv
// rtl/c10_bist_ctrl.sv - LFSR stimulus / CRC compaction self-test stage for the C10 netlist (option: C10_BIST_RESP_REG_EN)
module c10_bist_ctrl #(
   parameter int               NUM_PATTERNS = 255,
   parameter logic [7:0]       SEED         = 8'h01,
   parameter int               SIG_W        = 16,
   parameter logic [SIG_W-1:0] SIG_POLY     = 16'h1021
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [7:0]       pattern,
   input  logic             dut_out,
   input  logic [SIG_W-1:0] golden,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [7:0]       pat_count
);

   // An all-zero seed would lock the LFSR at zero forever, so it is replaced.
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [7:0] LAST_CNT = 8'(NUM_PATTERNS - 1);
   localparam logic [7:0] MAX_CNT  = 8'(NUM_PATTERNS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state;
   state_t state_nx;

   // Galois right-shift LFSR, taps 8'hB8, maximal length 255.
   function automatic logic [7:0] lfsr_next(input logic [7:0] p);
      return (p >> 1) ^ (p[0] ? 8'hB8 : 8'h00);
   endfunction

   // Serial CRC step absorbing one response bit, MSB-first.
   function automatic logic [SIG_W-1:0] crc_next(input logic [SIG_W-1:0] s, input logic b);
      return {s[SIG_W-2:0], 1'b0} ^ ((s[SIG_W-1] ^ b) ? SIG_POLY : {SIG_W{1'b0}});
   endfunction

`ifdef C10_BIST_RESP_REG_EN
   logic dut_q;

   // Response capture register; cuts the pattern -> DUT -> signature path.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dut_q <= 1'b0;
      end else begin
         dut_q <= dut_out;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; abort beats start and only acts while a run is active.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               state_nx = S_LOAD;
            end
         end
         S_LOAD: begin
            state_nx = abort ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else if (pat_count == LAST_CNT) begin
`ifdef C10_BIST_RESP_REG_EN
               state_nx = S_FLUSH;
`else
               state_nx = S_DONE;
`endif
            end
         end
         S_FLUSH: begin
            state_nx = abort ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            if (start && !abort) begin
               state_nx = S_LOAD;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Status outputs decoded from the state; pass is live-compared while in DONE.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      pass = 1'b0;
      case (state)
         S_LOAD, S_RUN, S_FLUSH: begin
            busy = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
            pass = (signature == golden);
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Datapath: seed in LOAD, step LFSR and compact response in RUN; an abort freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern   <= 8'h00;
         signature <= {SIG_W{1'b0}};
         pat_count <= 8'h00;
      end else if (!abort) begin
         case (state)
            S_LOAD: begin
               pattern   <= SEED_EFF;
               signature <= {SIG_W{1'b0}};
               pat_count <= 8'h00;
            end
            S_RUN: begin
               pattern <= lfsr_next(pattern);
               if (pat_count < MAX_CNT) begin
                  pat_count <= pat_count + 8'd1;
               end
`ifdef C10_BIST_RESP_REG_EN
               // First RUN cycle is a bubble: dut_q still holds the LOAD-cycle response.
               if (pat_count != 8'h00) begin
                  signature <= crc_next(signature, dut_q);
               end
`else
               signature <= crc_next(signature, dut_out);
`endif
            end
`ifdef C10_BIST_RESP_REG_EN
            S_FLUSH: begin
               signature <= crc_next(signature, dut_q);
            end
`endif
            default: begin
               pattern <= pattern;
            end
         endcase
      end
   end

endmodule
